// File: rtl/wordle_pkg.sv
// wordle_pkg: shared constants, score codes and scorer state encoding for the Wordle guess scorer.
package wordle_pkg;
    localparam int WORD_LEN = 5;
    localparam int LETTER_W = 8;

    localparam logic [1:0] SC_BLANK  = 2'b00;
    localparam logic [1:0] SC_GRAY   = 2'b01;
    localparam logic [1:0] SC_YELLOW = 2'b10;
    localparam logic [1:0] SC_GREEN  = 2'b11;

    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_Z = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_DONE
    } state_e;

    function automatic logic is_letter(input logic [7:0] c);
        return c >= CH_A && c <= CH_Z;
    endfunction
endpackage

// File: rtl/wordle_letter_match.sv
// wordle_letter_match: finds the lowest unused answer position holding the given letter (one-hot j).
module wordle_letter_match #(
    parameter int WORD_LEN = wordle_pkg::WORD_LEN,
    parameter int LETTER_W = wordle_pkg::LETTER_W
) (
    input  logic [LETTER_W-1:0]          letter,
    input  logic [WORD_LEN*LETTER_W-1:0] answer,
    input  logic [WORD_LEN-1:0]          used,
    output logic                         found,
    output logic [WORD_LEN-1:0]          j
);
    // Scan from the rightmost letter down so the last hit taken is the lowest index.
    always_comb begin
        found = 1'b0;
        j     = '0;
        for (int k = WORD_LEN - 1; k >= 0; k--) begin
            if (!used[k] && answer[(WORD_LEN-1-k)*LETTER_W +: LETTER_W] == letter) begin
                found = 1'b1;
                j     = '0;
                j[k]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wordle_guess_scorer.sv
// wordle_guess_scorer: sequential Wordle scorer (green pass then yellow pass) with registered score/win/invalid.
// Define WORDLE_HARD_MODE_EN to add the hard_viol output and the previous-guess history.
module wordle_guess_scorer #(
    parameter int WORD_LEN = wordle_pkg::WORD_LEN,
    parameter int LETTER_W = wordle_pkg::LETTER_W
) (
    input  logic                         board_clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         new_game,
    input  logic [WORD_LEN*LETTER_W-1:0] guess,
    input  logic [WORD_LEN*LETTER_W-1:0] answer,
    output logic                         busy,
    output logic                         done,
    output logic [2*WORD_LEN-1:0]        score,
    output logic                         win,
    output logic                         invalid
`ifdef WORDLE_HARD_MODE_EN
    ,
    output logic                         hard_viol
`endif
);
    import wordle_pkg::*;

    typedef logic [WORD_LEN-1:0][LETTER_W-1:0] word_t;
    typedef logic [WORD_LEN-1:0][1:0]          score_t;

    localparam logic [2:0] LAST = 3'(WORD_LEN - 1);

    state_e                state_q, state_d;
    word_t                 g_q, g_d, a_q, a_d, guess_w;
    score_t                sc_q, sc_d;
    logic [WORD_LEN-1:0]   used_q, used_d, hit_j;
    logic [2:0]            idx_q, idx_d, pos;
    logic                  inv_q, inv_d;
    logic                  done_q, done_d, win_q, win_d, invalid_q, invalid_d;
    logic [2*WORD_LEN-1:0] score_q, score_d;
    logic                  guess_bad, found, last, commit;

    // Packed arrays put letter 0 at the top index, so letter idx lives at pos.
    assign guess_w = guess;
    assign pos     = LAST - idx_q;
    assign last    = idx_q == LAST;
    assign commit  = (state_q == ST_YELLOW && last) || (state_q == ST_DONE && inv_q);

    always_comb begin
        guess_bad = 1'b0;
        for (int k = 0; k < WORD_LEN; k++) guess_bad |= !is_letter(guess_w[k]);
    end

    wordle_letter_match #(
        .WORD_LEN(WORD_LEN),
        .LETTER_W(LETTER_W)
    ) u_match (
        .letter(g_q[pos]),
        .answer(a_q),
        .used  (used_q),
        .found (found),
        .j     (hit_j)
    );

`ifdef WORDLE_HARD_MODE_EN
    word_t               hg_q, hg_d;
    score_t              hs_q, hs_d;
    logic                hv_q, hv_d;
    logic [WORD_LEN-1:0] viol;

    always_comb begin
        viol = '0;
        for (int k = 0; k < WORD_LEN; k++) viol[k] = hs_q[k] == SC_GREEN && hg_q[k] != g_q[k];
    end
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        a_d     = a_q;
        sc_d    = sc_q;
        used_d  = used_q;
        idx_d   = idx_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    g_d     = guess;
                    a_d     = answer;
                    sc_d    = {WORD_LEN{SC_BLANK}};
                    used_d  = '0;
                    idx_d   = '0;
                    inv_d   = guess_bad;
                    state_d = guess_bad ? ST_DONE : ST_GREEN;
                end
            end
            ST_GREEN: begin
                if (g_q[pos] == a_q[pos]) begin
                    sc_d[pos]     = SC_GREEN;
                    used_d[idx_q] = 1'b1;
                end
                idx_d   = last ? 3'd0 : idx_q + 3'd1;
                state_d = last ? ST_YELLOW : ST_GREEN;
            end
            ST_YELLOW: begin
                if (sc_q[pos] != SC_GREEN) begin
                    sc_d[pos] = found ? SC_YELLOW : SC_GRAY;
                    used_d    = used_q | hit_j;
                end
                idx_d   = last ? 3'd0 : idx_q + 3'd1;
                state_d = last ? ST_DONE : ST_YELLOW;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d    = commit;
        score_d   = commit ? sc_d : score_q;
        win_d     = commit ? &sc_d : win_q;
        invalid_d = commit ? inv_q : invalid_q;
`ifdef WORDLE_HARD_MODE_EN
        hv_d = commit ? !inv_q && |viol : hv_q;
        hg_d = commit && !inv_q ? g_q : hg_q;
        hs_d = commit && !inv_q ? sc_d : hs_q;
`endif
        if (new_game) begin
            state_d   = ST_IDLE;
            done_d    = 1'b0;
            score_d   = '0;
            win_d     = 1'b0;
            invalid_d = 1'b0;
`ifdef WORDLE_HARD_MODE_EN
            hv_d = 1'b0;
            hg_d = '0;
            hs_d = '0;
`endif
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            g_q       <= '0;
            a_q       <= '0;
            sc_q      <= '0;
            used_q    <= '0;
            idx_q     <= '0;
            inv_q     <= 1'b0;
            done_q    <= 1'b0;
            score_q   <= '0;
            win_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            a_q       <= a_d;
            sc_q      <= sc_d;
            used_q    <= used_d;
            idx_q     <= idx_d;
            inv_q     <= inv_d;
            done_q    <= done_d;
            score_q   <= score_d;
            win_q     <= win_d;
            invalid_q <= invalid_d;
        end
    end

`ifdef WORDLE_HARD_MODE_EN
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            hg_q <= '0;
            hs_q <= '0;
            hv_q <= 1'b0;
        end else begin
            hg_q <= hg_d;
            hs_q <= hs_d;
            hv_q <= hv_d;
        end
    end

    assign hard_viol = hv_q;
`endif

    assign busy    = state_q == ST_GREEN || state_q == ST_YELLOW;
    assign done    = done_q;
    assign score   = score_q;
    assign win     = win_q;
    assign invalid = invalid_q;
endmodule

// File: tb/tb_wordle_guess_scorer.sv
// tb_wordle_guess_scorer: table-driven vectors plus directed abort/ignore/reset sequences for wordle_guess_scorer.
module tb_wordle_guess_scorer;
    logic        board_clk = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        new_game  = 1'b0;
    logic [39:0] guess     = '0;
    logic [39:0] answer    = '0;
    logic        busy, done, win, invalid;
    logic [9:0]  score;
`ifdef WORDLE_HARD_MODE_EN
    logic        hard_viol;
`endif

    int checks = 0;
    int errors = 0;

    always #5 board_clk = ~board_clk;

    wordle_guess_scorer dut (
        .board_clk(board_clk),
        .reset    (reset),
        .start    (start),
        .new_game (new_game),
        .guess    (guess),
        .answer   (answer),
        .busy     (busy),
        .done     (done),
        .score    (score),
        .win      (win),
        .invalid  (invalid)
`ifdef WORDLE_HARD_MODE_EN
        ,
        .hard_viol(hard_viol)
`endif
    );

    typedef struct {
        logic [39:0] g;
        logic [39:0] a;
        logic [9:0]  sc;
        logic        w;
        logic        inv;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [39:0] g, input logic [39:0] a, input logic [9:0] esc,
                       input logic ew, input logic einv, input string nm);
        int lat, bc;
        @(negedge board_clk);
        guess  = g;
        answer = a;
        start  = 1'b1;
        @(negedge board_clk);
        start  = 1'b0;
        guess  = "QQQQQ";
        answer = "QQQQQ";
        lat = 0;
        bc  = 0;
        while (!done && lat < 30) begin
            bc += int'(busy);
            @(negedge board_clk);
            lat++;
        end
        chk({nm, " latency"}, lat, einv ? 1 : 10);
        chk({nm, " busy cycles"}, bc, einv ? 0 : 10);
        chk({nm, " score"}, score, esc);
        chk({nm, " win"}, win, ew);
        chk({nm, " invalid"}, invalid, einv);
        @(negedge board_clk);
        chk({nm, " done pulse"}, done, 1'b0);
        chk({nm, " score hold"}, score, esc);
    endtask

    initial begin
        int ndone;
        logic [9:0] seen;
        vecs[0]  = '{"CRANE", "CRANE", 10'h3FF, 1'b1, 1'b0};
        vecs[1]  = '{"PAPER", "APPLE", 10'h2B9, 1'b0, 1'b0};
        vecs[2]  = '{"BOBBY", "ABBEY", 10'h277, 1'b0, 1'b0};
        vecs[3]  = '{"ZZZZZ", "CRANE", 10'h155, 1'b0, 1'b0};
        vecs[4]  = '{"EARTH", "HEART", 10'h2AA, 1'b0, 1'b0};
        vecs[5]  = '{"SPEED", "ERASE", 10'h269, 1'b0, 1'b0};
        vecs[6]  = '{"LLAMA", "HELLO", 10'h295, 1'b0, 1'b0};
        vecs[7]  = '{"AZZZZ", "ZZZZA", 10'h2FE, 1'b0, 1'b0};
        vecs[8]  = '{"CR4NE", "CRANE", 10'h000, 1'b0, 1'b1};
        vecs[9]  = '{"crane", "CRANE", 10'h000, 1'b0, 1'b1};
        vecs[10] = '{"@ZZZZ", "CRANE", 10'h000, 1'b0, 1'b1};
        vecs[11] = '{"ZZZZ[", "CRANE", 10'h000, 1'b0, 1'b1};

        #12;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset score", score, 10'h000);
        chk("reset win", win, 1'b0);
        chk("reset invalid", invalid, 1'b0);
`ifdef WORDLE_HARD_MODE_EN
        chk("reset hard_viol", hard_viol, 1'b0);
`endif
        @(negedge board_clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run(vecs[i].g, vecs[i].a, vecs[i].sc, vecs[i].w, vecs[i].inv, $sformatf("vec%0d", i));

        // A second start while busy must be dropped, not queued.
        @(negedge board_clk);
        guess  = "CRANE";
        answer = "CRANE";
        start  = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        repeat (2) @(negedge board_clk);
        guess  = "PAPER";
        answer = "APPLE";
        start  = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        ndone = 0;
        seen  = '0;
        for (int c = 0; c < 25; c++) begin
            if (done) begin
                ndone++;
                seen = score;
            end
            @(negedge board_clk);
        end
        chk("ignored start done count", ndone, 1);
        chk("ignored start score", seen, 10'h3FF);

        // Asynchronous reset mid-operation.
        guess  = "PAPER";
        answer = "APPLE";
        start  = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        repeat (3) @(negedge board_clk);
        #2 reset = 1'b1;
        #1;
        chk("async reset busy", busy, 1'b0);
        chk("async reset score", score, 10'h000);
        chk("async reset win", win, 1'b0);
        @(negedge board_clk);
        reset = 1'b0;

        // new_game four cycles after start aborts with no done.
        run("CRANE", "CRANE", 10'h3FF, 1'b1, 1'b0, "pre abort");
        @(negedge board_clk);
        guess  = "PAPER";
        answer = "APPLE";
        start  = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        repeat (3) @(negedge board_clk);
        new_game = 1'b1;
        @(negedge board_clk);
        new_game = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort score", score, 10'h000);
        chk("abort win", win, 1'b0);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            ndone += int'(done);
            @(negedge board_clk);
        end
        chk("abort done count", ndone, 0);

        // new_game beats a simultaneous start.
        guess    = "CRANE";
        answer   = "CRANE";
        start    = 1'b1;
        new_game = 1'b1;
        @(negedge board_clk);
        start    = 1'b0;
        new_game = 1'b0;
        chk("new_game wins busy", busy, 1'b0);
        @(negedge board_clk);
        chk("new_game wins busy later", busy, 1'b0);

`ifdef WORDLE_HARD_MODE_EN
        run("CRATE", "CRANE", 10'h3F7, 1'b0, 1'b0, "hard crate");
        chk("hard first guess", hard_viol, 1'b0);
        run("BRINE", "CRANE", 10'h1DF, 1'b0, 1'b0, "hard brine");
        chk("hard brine viol", hard_viol, 1'b1);
        @(negedge board_clk);
        new_game = 1'b1;
        @(negedge board_clk);
        new_game = 1'b0;
        chk("hard cleared", hard_viol, 1'b0);
        run("CRATE", "CRANE", 10'h3F7, 1'b0, 1'b0, "hard crate2");
        run("CRAZE", "CRANE", 10'h3F7, 1'b0, 1'b0, "hard craze");
        chk("hard craze ok", hard_viol, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
